// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_expand
//  Purpose  : Iterative AES-128 key schedule. Presents round keys 0..10 one
//             at a time with a valid/ready handshake towards a downstream
//             AddRoundKey stage. One new round key is computed per NEXT state.
//  Ports    : iClk, iRst_n (async, active-low)
//             iStart/iKey          - start pulse and cipher key (IDLE only)
//             iKeyReady            - downstream consumes current round key
//             oKeyValid/oRound/oRoundKey - presented round key and its index
//             oBusy/oDone          - not-idle flag, one-cycle completion pulse
//             iRdRound/oRdKey      - stored round-key readback
//  Config   : KEY_EXPAND_STORE_EN - when defined, an 11x128 round-key store
//             is built and read through iRdRound/oRdKey; otherwise oRdKey=0.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_key_expand (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iStart,
    input  logic [127:0] iKey,
    input  logic         iKeyReady,
    output logic         oKeyValid,
    output logic [3:0]   oRound,
    output logic [127:0] oRoundKey,
    output logic         oBusy,
    output logic         oDone,
    input  logic [3:0]   iRdRound,
    output logic [127:0] oRdKey
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_PRESENT = 2'd1;
    localparam logic [1:0] c_NEXT    = 2'd2;
    localparam logic [3:0] c_LAST    = 4'd10;

    logic [1:0]   r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic         r_done;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [7:0]   w_rcon;
    logic [31:0]  w_temp;
    logic [127:0] w_next_key;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    // Rcon for the round being produced (r_round + 1).
    always_comb begin
        w_rcon = 8'h00;
        case (r_round)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_temp = w_sub ^ {w_rcon, 24'h000000};

    // Each word chains off the freshly computed previous word.
    always_comb begin
        logic [31:0] v0, v1, v2, v3;
        v0 = w_w0 ^ w_temp;
        v1 = w_w1 ^ v0;
        v2 = w_w2 ^ v1;
        v3 = w_w3 ^ v2;
        w_next_key = {v0, v1, v2, v3};
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= c_IDLE;
            r_key   <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (iStart) begin
                        r_key   <= iKey;
                        r_round <= '0;
                        r_state <= c_PRESENT;
                    end
                end
                c_PRESENT: begin
                    if (iKeyReady) begin
                        if (r_round == c_LAST) begin
                            // Key and round stay at round 10 until the next start.
                            r_done  <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_state <= c_NEXT;
                        end
                    end
                end
                c_NEXT: begin
                    r_key   <= w_next_key;
                    r_round <= r_round + 4'd1;
                    r_state <= c_PRESENT;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign oKeyValid = (r_state == c_PRESENT);
    assign oBusy     = (r_state != c_IDLE);
    assign oDone     = r_done;
    assign oRound    = r_round;
    assign oRoundKey = r_key;

`ifdef KEY_EXPAND_STORE_EN
    logic [127:0] r_store [0:10];

    // Written on the same edge that makes the round key valid.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < 11; i++) begin
                r_store[i] <= '0;
            end
        end else if ((r_state == c_IDLE) && iStart) begin
            r_store[0] <= iKey;
        end else if (r_state == c_NEXT) begin
            r_store[r_round + 4'd1] <= w_next_key;
        end
    end

    assign oRdKey = (iRdRound <= c_LAST) ? r_store[iRdRound] : '0;
`else
    // Constant zero; the read index is folded in only so the port has a load.
    assign oRdKey = {128{1'b0}} & {128{^iRdRound}};
`endif

endmodule

// ============================================================================
//  Module   : aes_sbox
//  Purpose  : Combinational AES forward S-box lookup (byte in, byte out).
//  Ports    : i_byte - input byte, o_byte - substituted byte
//  Revision : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 occupies the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_SBOX[11'd2047 - {i_byte, 3'b000} -: 8];

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_key_expand
//  Purpose  : Self-checking bench for aes_key_expand. Reference key schedule
//             is computed from GF(2^8) arithmetic (S-box built from the
//             multiplicative inverse plus affine map).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand;

    logic         iClk;
    logic         iRst_n;
    logic         iStart;
    logic [127:0] iKey;
    logic         iKeyReady;
    logic         oKeyValid;
    logic [3:0]   oRound;
    logic [127:0] oRoundKey;
    logic         oBusy;
    logic         oDone;
    logic [3:0]   iRdRound;
    logic [127:0] oRdKey;

    aes_key_expand u_dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iStart    (iStart),
        .iKey      (iKey),
        .iKeyReady (iKeyReady),
        .oKeyValid (oKeyValid),
        .oRound    (oRound),
        .oRoundKey (oRoundKey),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .iRdRound  (iRdRound),
        .oRdKey    (oRdKey)
    );

    localparam logic [127:0] c_K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_K2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] c_K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] c_MIX    = 128'hc3a2db82019e5193b8240c5189b37ea8;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           start_cyc = 0;
    logic [7:0]   sb_tab [256];
    logic [127:0] exp_rk [11];
    bit           kat_en;
    logic [127:0] kat1, kat10;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- driver / checker ----------------
    // Runs one expansion. All input changes and samples happen on negedges.
    task automatic run_key(input logic [127:0] key, input bit skip_start,
                           input int stall_pct, input int stall5_round,
                           input int busy_start_round, input int abort_round,
                           input bit chain, input logic [127:0] chain_key);
        int stalls, n;
        stalls = 0;
        model_expand(key);
        if (!skip_start) begin
            iKey = key;
            iStart = 1'b1;
            start_cyc = cyc;
            @(negedge iClk);
            iStart = 1'b0;
        end
        iKey = {$urandom, $urandom, $urandom, $urandom};
        for (int r = 0; r <= 10; r++) begin
            check_val($sformatf("valid_r%0d", r), 128'(oKeyValid), 128'd1);
            check_val($sformatf("round_r%0d", r), 128'(oRound), 128'(r));
            check_val($sformatf("key_r%0d", r), oRoundKey, exp_rk[r]);
            if (kat_en && r == 1) check_val("kat_r1", oRoundKey, kat1);
            if (kat_en && r == 10) check_val("kat_r10", oRoundKey, kat10);
            if (r == 1) check_val("addroundkey_r1", oRoundKey ^ c_MIX, exp_rk[1] ^ c_MIX);
            if (r == abort_round) begin
                @(posedge iClk);
                #2 iRst_n = 1'b0;
                iRdRound = 4'd0;
                #1;
                check_val("rst_valid", 128'(oKeyValid), 128'd0);
                check_val("rst_round", 128'(oRound), 128'd0);
                check_val("rst_key", oRoundKey, 128'd0);
                check_val("rst_busy", 128'(oBusy), 128'd0);
                check_val("rst_done", 128'(oDone), 128'd0);
                check_val("rst_rdkey", oRdKey, 128'd0);
                @(negedge iClk);
                iRst_n = 1'b1;
                iKeyReady = 1'b0;
                @(negedge iClk);
                check_val("rst_nodone", 128'(oDone), 128'd0);
                check_val("rst_idle", 128'(oBusy), 128'd0);
                return;
            end
            if (r == busy_start_round) begin
                iStart = 1'b1;
                iKey = c_K2;
                iKeyReady = 1'b0;
                @(negedge iClk);
                iStart = 1'b0;
                stalls++;
                check_val("busy_start_round", 128'(oRound), 128'(r));
                check_val("busy_start_key", oRoundKey, exp_rk[r]);
            end
            if (r == stall5_round) n = 5;
            else n = ($urandom_range(0, 99) < stall_pct) ? $urandom_range(1, 3) : 0;
            iKeyReady = 1'b0;
            for (int s = 0; s < n; s++) begin
                @(negedge iClk);
                stalls++;
                check_val("stall_valid", 128'(oKeyValid), 128'd1);
                check_val("stall_round", 128'(oRound), 128'(r));
                check_val("stall_key", oRoundKey, exp_rk[r]);
            end
            iKeyReady = 1'b1;
            @(negedge iClk);
            iKeyReady = 1'b0;
            if (r < 10) begin
                check_val("next_valid", 128'(oKeyValid), 128'd0);
                check_val("next_busy", 128'(oBusy), 128'd1);
                check_val("next_done", 128'(oDone), 128'd0);
                @(negedge iClk);
            end else begin
                check_val("done_pulse", 128'(oDone), 128'd1);
                check_val("done_valid", 128'(oKeyValid), 128'd0);
                check_val("done_busy", 128'(oBusy), 128'd0);
                check_val("done_latency", 128'(cyc - start_cyc - 1), 128'(21 + stalls));
                if (chain) begin
                    iKey = chain_key;
                    iStart = 1'b1;
                    start_cyc = cyc;
                    @(negedge iClk);
                    iStart = 1'b0;
                end else begin
                    @(negedge iClk);
                    check_val("done_single", 128'(oDone), 128'd0);
                    check_val("hold_round", 128'(oRound), 128'd10);
                    check_val("hold_key", oRoundKey, exp_rk[10]);
                end
            end
        end
    endtask

    task automatic check_store();
`ifdef KEY_EXPAND_STORE_EN
        for (int r = 0; r < 11; r++) begin
            iRdRound = 4'(r);
            #1 check_val($sformatf("store_r%0d", r), oRdKey, exp_rk[r]);
        end
        iRdRound = 4'd12;
        #1 check_val("store_oob", oRdKey, 128'd0);
`else
        for (int i = 0; i < 3; i++) begin
            iRdRound = 4'($urandom_range(0, 15));
            #1 check_val("rdkey_tied", oRdKey, 128'd0);
        end
`endif
    endtask

    initial begin
        iRst_n = 1'b0;
        iStart = 1'b0;
        iKey = '0;
        iKeyReady = 1'b0;
        iRdRound = 4'd0;
        kat_en = 1'b0;
        kat1 = '0;
        kat10 = '0;
        build_sbox();
        repeat (3) @(negedge iClk);
        check_val("reset_valid", 128'(oKeyValid), 128'd0);
        check_val("reset_round", 128'(oRound), 128'd0);
        check_val("reset_key", oRoundKey, 128'd0);
        check_val("reset_busy", 128'(oBusy), 128'd0);
        check_val("reset_done", 128'(oDone), 128'd0);
        check_val("reset_rdkey", oRdKey, 128'd0);
        iRst_n = 1'b1;
        @(negedge iClk);

        // Known-answer expansion, full readiness.
        kat_en = 1'b1; kat1 = c_K1_R1; kat10 = c_K1_R10;
        run_key(c_K1, 1'b0, 0, -1, -1, -1, 1'b0, '0);
        check_store();
        @(negedge iClk);

        // Five-cycle backpressure at round 3.
        run_key(c_K1, 1'b0, 0, 3, -1, -1, 1'b0, '0);

        // Start while busy (ignored), then start in the oDone cycle (accepted).
        run_key(c_K1, 1'b0, 0, -1, 4, -1, 1'b1, c_K2);
        kat1 = c_K2_R1; kat10 = c_K2_R10;
        run_key(c_K2, 1'b1, 0, -1, -1, -1, 1'b0, '0);

        // Asynchronous reset at round 6, then a clean rerun.
        kat1 = c_K1_R1; kat10 = c_K1_R10;
        run_key(c_K1, 1'b0, 0, -1, -1, 6, 1'b0, '0);
        run_key(c_K1, 1'b0, 30, -1, -1, -1, 1'b0, '0);
        check_store();

        // Random keys with random backpressure.
        kat_en = 1'b0;
        for (int t = 0; t < 6; t++) begin
            run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, 40, -1, -1, -1, 1'b0, '0);
        end
        check_store();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
